// File: rtl/acia_rx_pkg.sv
// Shared definitions for the 6551-style ACIA receiver: word-length and parity codes,
// receive FSM states and small decode/parity helpers.
package acia_rx_pkg;

    localparam logic [1:0] WL_8 = 2'b00;
    localparam logic [1:0] WL_7 = 2'b01;
    localparam logic [1:0] WL_6 = 2'b10;
    localparam logic [1:0] WL_5 = 2'b11;

    localparam logic [1:0] PMC_ODD   = 2'b00;
    localparam logic [1:0] PMC_EVEN  = 2'b01;
    localparam logic [1:0] PMC_MARK  = 2'b10;
    localparam logic [1:0] PMC_SPACE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_DATA     = 3'd2,
        ST_PARITY   = 3'd3,
        ST_STOP     = 3'd4,
        ST_BRK_WAIT = 3'd5
    } rx_state_e;

    function automatic logic [3:0] wl_bits(input logic [1:0] wl);
        case (wl)
            WL_8:    return 4'd8;
            WL_7:    return 4'd7;
            WL_6:    return 4'd6;
            WL_5:    return 4'd5;
            default: return 4'd8;
        endcase
    endfunction

    // Unused upper data bits are zero, so XOR over all eight bits equals XOR over WL bits.
    function automatic logic parity_expected(input logic [7:0] data, input logic [1:0] pmc);
        case (pmc)
            PMC_ODD:   return ~(^data);
            PMC_EVEN:  return ^data;
            PMC_MARK:  return 1'b1;
            PMC_SPACE: return 1'b0;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/acia_rx_if.sv
// Receiver-side signal bundle between the baud generator / register file and acia_rx.
interface acia_rx_if;
    logic       RX16_TICK;
    logic       RXD;
    logic [1:0] R_WL;
    logic       R_PME;
    logic [1:0] R_PMC;
    logic       RD_STB;
    logic [7:0] RX_DATA;
    logic       RDRF;
    logic       PE;
    logic       FE;
    logic       OVR;
    logic       RX_ACTIVE;

    modport master (
        output RX16_TICK, RXD, R_WL, R_PME, R_PMC, RD_STB,
        input  RX_DATA, RDRF, PE, FE, OVR, RX_ACTIVE
    );

    modport slave (
        input  RX16_TICK, RXD, R_WL, R_PME, R_PMC, RD_STB,
        output RX_DATA, RDRF, PE, FE, OVR, RX_ACTIVE
    );
endinterface

// File: rtl/acia_rx_sync.sv
// Two-flop synchronizer for asynchronous idle-high serial/modem inputs; presets to 1.
module acia_rx_sync (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] sync_q;

    // Metastability chain; reset to the idle (high) level so no false start is seen.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];
endmodule

// File: rtl/acia_rx.sv
// 6551-compatible receiver: 16x oversampled start/data/parity/stop deserialiser with
// receive data register, RDRF and parity/framing/overrun flags.
module acia_rx #(
    parameter logic [3:0] SAMPLE_MID = 4'd7
) (
    input  logic     XTLI,
    input  logic     RESET,
    acia_rx_if.slave bus
);
    import acia_rx_pkg::*;

    logic       rxd_s;
    rx_state_e  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] bit_q, bit_d;
    logic [7:0] shreg_q, shreg_d;
    logic [1:0] wl_q, wl_d;
    logic       pme_q, pme_d;
    logic [1:0] pmc_q, pmc_d;
    logic       pe_nx_q, pe_nx_d;
    logic       ld_q, ld_d;
    logic       ld_fe_q, ld_fe_d;
    logic       active_q, active_d;
    logic [7:0] data_q, data_d;
    logic       rdrf_q, rdrf_d;
    logic       pe_q, pe_d;
    logic       fe_q, fe_d;
    logic       ovr_q, ovr_d;

    acia_rx_sync u_sync (
        .clk_i   (XTLI),
        .rst_n_i (RESET),
        .d_i     (bus.RXD),
        .q_o     (rxd_s)
    );

    // Frame FSM: advances only on 16x ticks; frame settings are latched at start validation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        wl_d     = wl_q;
        pme_d    = pme_q;
        pmc_d    = pmc_q;
        pe_nx_d  = pe_nx_q;
        ld_d     = 1'b0;
        ld_fe_d  = ld_fe_q;
        if (bus.RX16_TICK) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rxd_s) begin
                        state_d = ST_START;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_START: begin
                    if (cnt_q == SAMPLE_MID) begin
                        if (rxd_s) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_DATA;
                            cnt_d   = 4'd0;
                            bit_d   = 4'd0;
                            shreg_d = 8'h00;
                            pe_nx_d = 1'b0;
                            wl_d    = bus.R_WL;
                            pme_d   = bus.R_PME;
                            pmc_d   = bus.R_PMC;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                ST_DATA: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        shreg_d[bit_q[2:0]] = rxd_s;
                        bit_d = bit_q + 4'd1;
                        if ((bit_q + 4'd1) == wl_bits(wl_q)) begin
                            state_d = pme_q ? ST_PARITY : ST_STOP;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_PARITY: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        pe_nx_d = (rxd_s != parity_expected(shreg_q, pmc_q));
                        state_d = ST_STOP;
                    end else begin
                        state_d = ST_PARITY;
                    end
                end
                ST_STOP: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        ld_d    = 1'b1;
                        ld_fe_d = ~rxd_s;
                        state_d = rxd_s ? ST_IDLE : ST_BRK_WAIT;
                    end else begin
                        state_d = ST_STOP;
                    end
                end
                ST_BRK_WAIT: begin
                    if (rxd_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_BRK_WAIT;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        active_d = (state_d == ST_START) || (state_d == ST_DATA) ||
                   (state_d == ST_PARITY) || (state_d == ST_STOP);
    end

    // Receive data register: a CPU read is applied before a same-cycle load, so it never overruns.
    always_comb begin
        data_d = data_q;
        pe_d   = pe_q;
        fe_d   = fe_q;
        rdrf_d = rdrf_q;
        ovr_d  = ovr_q;
        if (bus.RD_STB) begin
            rdrf_d = 1'b0;
            ovr_d  = 1'b0;
        end else begin
            rdrf_d = rdrf_q;
        end
        if (ld_q) begin
            if (rdrf_d) begin
                ovr_d = 1'b1;
            end else begin
                data_d = shreg_q;
                pe_d   = pe_nx_q;
                fe_d   = ld_fe_q;
                rdrf_d = 1'b1;
            end
        end else begin
            data_d = data_q;
        end
    end

    // State and register update.
    always_ff @(posedge XTLI or negedge RESET) begin
        if (!RESET) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            bit_q    <= 4'd0;
            shreg_q  <= 8'h00;
            wl_q     <= 2'b00;
            pme_q    <= 1'b0;
            pmc_q    <= 2'b00;
            pe_nx_q  <= 1'b0;
            ld_q     <= 1'b0;
            ld_fe_q  <= 1'b0;
            active_q <= 1'b0;
            data_q   <= 8'h00;
            rdrf_q   <= 1'b0;
            pe_q     <= 1'b0;
            fe_q     <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            wl_q     <= wl_d;
            pme_q    <= pme_d;
            pmc_q    <= pmc_d;
            pe_nx_q  <= pe_nx_d;
            ld_q     <= ld_d;
            ld_fe_q  <= ld_fe_d;
            active_q <= active_d;
            data_q   <= data_d;
            rdrf_q   <= rdrf_d;
            pe_q     <= pe_d;
            fe_q     <= fe_d;
            ovr_q    <= ovr_d;
        end
    end

    assign bus.RX_DATA   = data_q;
    assign bus.RDRF      = rdrf_q;
    assign bus.PE        = pe_q;
    assign bus.FE        = fe_q;
    assign bus.OVR       = ovr_q;
    assign bus.RX_ACTIVE = active_q;
endmodule

// File: tb/tb_acia_rx.sv
// Directed bench for acia_rx: 16x tick every 4 clocks, so one bit time is 64 clocks.
module tb_acia_rx;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   tick_div;

    acia_rx_if bus ();

    acia_rx #(.SAMPLE_MID(4'd7)) dut (
        .XTLI  (clk),
        .RESET (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // 16x baud enable: one-cycle pulse every fourth clock.
    initial begin
        bus.RX16_TICK = 1'b0;
        tick_div = 0;
        forever begin
            @(negedge clk);
            tick_div = (tick_div + 1) % 4;
            bus.RX16_TICK = (tick_div == 0);
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic read_strobe();
        bus.RD_STB = 1'b1;
        @(negedge clk);
        bus.RD_STB = 1'b0;
    endtask

    task automatic set_cfg(input logic [1:0] wl, input logic pme, input logic [1:0] pmc);
        bus.R_WL  = wl;
        bus.R_PME = pme;
        bus.R_PMC = pmc;
    endtask

    // Start bit, nb data bits LSB first, optional parity, one stop bit, short idle.
    task automatic send_frame(input logic [7:0] d, input int nb, input logic pen,
                              input logic pb, input logic sb, input logic rd_at_load);
        logic found;
        bus.RXD = 1'b0;
        cycles(64);
        for (int i = 0; i < nb; i++) begin
            bus.RXD = d[i];
            cycles(64);
        end
        if (pen) begin
            bus.RXD = pb;
            cycles(64);
        end
        bus.RXD = sb;
        if (rd_at_load) begin
            found = 1'b0;
            for (int k = 0; k < 64 && !found; k++) begin
                @(negedge clk);
                if (!bus.RX_ACTIVE) found = 1'b1;
            end
            read_strobe();
            chk("load_edge_seen", {7'd0, found}, 8'h01);
            cycles(40);
        end else begin
            cycles(64);
        end
        bus.RXD = 1'b1;
        cycles(16);
    endtask

    initial begin
        logic saw;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.RXD = 1'b1;
        bus.RD_STB = 1'b0;
        set_cfg(2'b00, 1'b0, 2'b00);
        cycles(5);
        chk("rst_data", bus.RX_DATA, 8'h00);
        chk("rst_flags", {3'd0, bus.RDRF, bus.PE, bus.FE, bus.OVR, bus.RX_ACTIVE}, 8'h00);
        rst_n = 1'b1;
        cycles(20);

        // 8N1 0xA5
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("8n1_data", bus.RX_DATA, 8'hA5);
        chk("8n1_flags", {4'd0, bus.RDRF, bus.PE, bus.FE, bus.OVR}, 8'h08);
        read_strobe();
        chk("8n1_rd_rdrf", {7'd0, bus.RDRF}, 8'h00);
        chk("8n1_rd_data", bus.RX_DATA, 8'hA5);

        // 7E1: 0x41 has two ones, even parity bit is 0
        set_cfg(2'b01, 1'b1, 2'b01);
        send_frame(8'h41, 7, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("7e1_data", bus.RX_DATA, 8'h41);
        chk("7e1_pe_ok", {6'd0, bus.RDRF, bus.PE}, 8'h02);
        read_strobe();
        send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("7e1_pe_bad", {6'd0, bus.RDRF, bus.PE}, 8'h03);
        read_strobe();

        // 5-bit words: no parity, then mark parity received as 0
        set_cfg(2'b11, 1'b0, 2'b00);
        send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("5n1_data", bus.RX_DATA, 8'h1F);
        chk("5n1_pe", {7'd0, bus.PE}, 8'h00);
        read_strobe();
        set_cfg(2'b11, 1'b1, 2'b10);
        send_frame(8'h1F, 5, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("5m1_data", bus.RX_DATA, 8'h1F);
        chk("5m1_pe", {7'd0, bus.PE}, 8'h01);
        read_strobe();

        // Low glitch of 3 ticks on idle line: false start
        set_cfg(2'b00, 1'b0, 2'b00);
        saw = 1'b0;
        bus.RXD = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (k == 12) bus.RXD = 1'b1;
            @(negedge clk);
            if (bus.RX_ACTIVE) saw = 1'b1;
        end
        chk("glitch_active_pulse", {7'd0, saw}, 8'h01);
        chk("glitch_idle", {6'd0, bus.RDRF, bus.RX_ACTIVE}, 8'h00);

        // Overrun: second and third characters lost while RDRF=1
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ovr_first", {4'd0, bus.RDRF, bus.PE, bus.FE, bus.OVR}, 8'h08);
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ovr_second", {4'd0, bus.RDRF, bus.PE, bus.FE, bus.OVR}, 8'h09);
        send_frame(8'h33, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ovr_keep_data", bus.RX_DATA, 8'h55);
        read_strobe();
        chk("ovr_rd_clear", {6'd0, bus.RDRF, bus.OVR}, 8'h00);
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("rd_at_load_flags", {6'd0, bus.RDRF, bus.OVR}, 8'h02);
        chk("rd_at_load_data", bus.RX_DATA, 8'hC3);
        read_strobe();

        // Break: line low for 20 bit times
        bus.RXD = 1'b0;
        cycles(20 * 64);
        chk("brk_data", bus.RX_DATA, 8'h00);
        chk("brk_flags", {4'd0, bus.RDRF, bus.PE, bus.FE, bus.OVR}, 8'h0A);
        read_strobe();
        cycles(3 * 64);
        chk("brk_no_more", {6'd0, bus.RDRF, bus.RX_ACTIVE}, 8'h00);
        bus.RXD = 1'b1;
        cycles(64);
        send_frame(8'h96, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("post_brk_data", bus.RX_DATA, 8'h96);
        chk("post_brk_flags", {4'd0, bus.RDRF, bus.PE, bus.FE, bus.OVR}, 8'h08);

        // Reset in the middle of the data bits
        bus.RXD = 1'b0;
        cycles(64);
        bus.RXD = 1'b1;
        cycles(64);
        bus.RXD = 1'b0;
        cycles(30);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_data", bus.RX_DATA, 8'h00);
        chk("midrst_flags", {3'd0, bus.RDRF, bus.PE, bus.FE, bus.OVR, bus.RX_ACTIVE}, 8'h00);
        bus.RXD = 1'b1;
        cycles(3);
        rst_n = 1'b1;
        cycles(100);
        chk("midrst_quiet", {6'd0, bus.RDRF, bus.RX_ACTIVE}, 8'h00);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("after_rst_data", bus.RX_DATA, 8'h3C);
        chk("after_rst_flags", {4'd0, bus.RDRF, bus.PE, bus.FE, bus.OVR}, 8'h08);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
